// File: rtl/serial_scheduler.sv
// Two-requester round-robin transmit scheduler and receive FIFO for a
// toggle-handshake serial controller.
module serial_scheduler #(
    parameter int RX_DEPTH   = 4,
    parameter int STOP_LEVEL = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    input  logic [15:0] req_data,
    output logic [1:0]  req_ready,
    output logic [7:0]  ser_data_write,
    output logic        ser_write_odd_request,
    input  logic        ser_write_odd,
    input  logic [7:0]  ser_data_read,
    input  logic        ser_read_odd,
    output logic        ser_try_stop_reading,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_pop,
    output logic [4:0]  rx_count,
    output logic        rx_overflow,
    input  logic        rx_clear
);

    localparam int         PTR_W   = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
    localparam logic [4:0] DEPTH_C = 5'(RX_DEPTH);
    localparam logic [4:0] STOP_C  = 5'(STOP_LEVEL);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t     state_q, state_d;
    logic       prio_q, prio_d;
    logic [7:0] data_q, data_d;
    logic       odd_req_q, odd_req_d;
    logic       grant_idx;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            prio_q    <= 1'b0;
            data_q    <= 8'h00;
            odd_req_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            prio_q    <= prio_d;
            data_q    <= data_d;
            odd_req_q <= odd_req_d;
        end
    end

    // prio_q names the requester that wins the next tie.
    always_comb begin
        state_d   = state_q;
        prio_d    = prio_q;
        data_d    = data_q;
        odd_req_d = odd_req_q;
        req_ready = 2'b00;
        grant_idx = prio_q;
        case (state_q)
            IDLE: begin
                if (!reset && (req_valid != 2'b00)) begin
                    grant_idx = (req_valid == 2'b11) ? prio_q : req_valid[1];
                    req_ready[grant_idx] = 1'b1;
                    data_d    = grant_idx ? req_data[15:8] : req_data[7:0];
                    odd_req_d = ~odd_req_q;
                    prio_d    = ~grant_idx;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                if (ser_write_odd == odd_req_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ser_data_write        = data_q;
    assign ser_write_odd_request = odd_req_q;

    logic [7:0]       mem [RX_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [4:0]       count_q, count_d;
    logic             rx_seen_q;
    logic             ovf_q, ovf_d;
    logic             stop_q;
    logic             rx_event, pop_acc, full, push, ovf_set;

    // A pop frees the slot a same-cycle receive into a full FIFO needs.
    always_comb begin
        rx_event = !reset && (ser_read_odd != rx_seen_q);
        pop_acc  = rx_pop && (count_q != 5'd0);
        full     = (count_q == DEPTH_C);
        push     = rx_event && (!full || pop_acc);
        ovf_set  = rx_event && full && !pop_acc;
        wr_ptr_d = push    ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop_acc ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop_acc) begin
            count_d = count_q + 5'd1;
        end else if (!push && pop_acc) begin
            count_d = count_q - 5'd1;
        end
        ovf_d = ovf_q;
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (rx_clear) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_seen_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= 5'd0;
            ovf_q     <= 1'b0;
            stop_q    <= 1'b0;
        end else begin
            rx_seen_q <= ser_read_odd;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            stop_q    <= (count_q >= STOP_C);
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_q] <= ser_data_read;
        end
    end

    assign rx_data              = mem[rd_ptr_q];
    assign rx_valid             = (count_q != 5'd0);
    assign rx_count             = count_q;
    assign rx_overflow          = ovf_q;
    assign ser_try_stop_reading = stop_q;

endmodule

// File: doc/serial_scheduler.md
SERIAL_SCHEDULER -- requirements
Module: serial_scheduler

Interface
REQ-001 SHALL have parameter RX_DEPTH, default 4, receive FIFO depth in bytes (power of two, 2..16).
REQ-002 SHALL have parameter STOP_LEVEL, default 3, RX FIFO occupancy at or above which ser_try_stop_reading asserts.
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  2  per-requester transmit request; bit i belongs to requester i.
REQ-006 SHALL have port req_data  input  16  transmit byte per requester; requester i uses bits [8i+7:8i].
REQ-007 SHALL have port req_ready  output  2  one-cycle grant pulse; the byte of that requester is captured in that cycle.
REQ-008 SHALL have port ser_data_write  output  8  byte presented to the serial controller.
REQ-009 SHALL have port ser_write_odd_request  output  1  transmit toggle; a change requests one byte.
REQ-010 SHALL have port ser_write_odd  input  1  transmit acknowledge toggle from the serial controller.
REQ-011 SHALL have port ser_data_read  input  8  received byte from the serial controller.
REQ-012 SHALL have port ser_read_odd  input  1  receive toggle; each change marks one new byte.
REQ-013 SHALL have port ser_try_stop_reading  output  1  flow-control request to the remote sender.
REQ-014 SHALL have port rx_data  output  8  head byte of the RX FIFO, valid when rx_valid=1.
REQ-015 SHALL have port rx_valid  output  1  RX FIFO non-empty.
REQ-016 SHALL have port rx_pop  input  1  consume head byte; ignored when rx_valid=0.
REQ-017 SHALL have port rx_count  output  5  current RX FIFO occupancy, 0..RX_DEPTH.
REQ-018 SHALL have port rx_overflow  output  1  sticky flag: a received byte was dropped.
REQ-019 SHALL have port rx_clear  input  1  clears rx_overflow.

Function
REQ-020 TX FSM SHALL have states IDLE and BUSY.
REQ-021 In IDLE with any req_valid bit set, SHALL grant one requester, pulse its req_ready bit, load ser_data_write with that requester's byte, invert ser_write_odd_request, and enter BUSY, all in the same cycle.
REQ-022 Arbitration SHALL be round-robin: on both requests, grant the requester not granted last; after reset, requester 0 wins the first tie.
REQ-023 In BUSY, SHALL hold ser_data_write and ser_write_odd_request stable and return to IDLE in the cycle after ser_write_odd equals ser_write_odd_request.
REQ-024 req_ready SHALL never be asserted in BUSY, never on more than one bit, and never on a bit whose req_valid is 0.
REQ-025 Minimum spacing between grants SHALL be 2 cycles (grant, wait at least one BUSY cycle).
REQ-026 SHALL register ser_read_odd into rx_seen; a mismatch between ser_read_odd and rx_seen SHALL be one receive event, consumed by updating rx_seen the same cycle.
REQ-027 A receive event with FIFO not full, or full with an accepted rx_pop the same cycle, SHALL write ser_data_read at the tail.
REQ-028 A receive event with FIFO full and no rx_pop SHALL drop the byte and set rx_overflow; FIFO contents stay unchanged.
REQ-029 Simultaneous push and pop SHALL leave rx_count unchanged; pointers SHALL wrap modulo RX_DEPTH.
REQ-030 rx_data SHALL be the head entry combinationally from storage; a push into an empty FIFO SHALL raise rx_valid the next cycle.
REQ-031 ser_try_stop_reading SHALL be registered and equal (rx_count >= STOP_LEVEL) with one cycle delay.
REQ-032 rx_clear SHALL clear rx_overflow next cycle; if an overflow occurs in the same cycle, rx_overflow SHALL end up 1.

Reset
REQ-033 On reset SHALL set: FSM IDLE, req_ready=0, ser_data_write=0, ser_write_odd_request=0, rx_seen=0, FIFO empty (rx_count=0, rx_valid=0), rx_overflow=0, ser_try_stop_reading=0, round-robin pointer to requester 0.
REQ-034 Reset mid-transmission SHALL abandon the BUSY wait with no further grant until reset deasserts; a pending receive event in the reset cycle SHALL be discarded.
REQ-035 Reset SHALL take priority over every other input in the same cycle.

Verification
REQ-036 req_valid=01, data 0x41, ack toggles 5 cycles later -> req_ready=01 one cycle, ser_write_odd_request 0->1, ser_data_write=0x41; IDLE again the cycle after ser_write_odd=1.
REQ-037 req_valid=11 held, data 0x10/0x20, instant acks -> grants alternate 01,10,01,10; bytes 0x10,0x20,0x10,0x20.
REQ-038 Four toggles on ser_read_odd with bytes 1..4, no pop -> rx_count=4, ser_try_stop_reading=1 from 3rd byte +1 cycle; fifth byte 5 -> dropped, rx_overflow=1; pops return 1,2,3,4.
REQ-039 FIFO full, receive event and rx_pop same cycle -> rx_count stays 4, head advances, new byte at tail, rx_overflow stays 0.
REQ-040 Reset asserted while BUSY with FIFO holding 2 bytes -> next cycle all outputs at REQ-033 values, rx_valid=0.
REQ-041 rx_clear and overflow event in the same cycle -> rx_overflow=1; rx_clear alone next cycle -> rx_overflow=0.
